// File: rtl/fc_l2_port_arbiter_if.sv
// Bundle of requester-side and L2-side signals of fc_l2_port_arbiter.
// The arbiter uses the slave modport. The environment (the requesters plus
// the L2 interconnect) uses the master modport.
interface fc_l2_port_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Requester side
    logic [N_REQ-1:0]            req_i;
    logic [N_REQ*ADDR_WIDTH-1:0] add_i;
    logic [N_REQ-1:0]            wen_i;
    logic [N_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [N_REQ*BE_WIDTH-1:0]   be_i;
    logic [N_REQ-1:0]            gnt_o;
    logic [N_REQ-1:0]            r_valid_o;
    logic [DATA_WIDTH-1:0]       r_rdata_o;
    logic                        r_opc_o;

    // L2 side
    logic                        req_o;
    logic [ADDR_WIDTH-1:0]       add_o;
    logic                        wen_o;
    logic [DATA_WIDTH-1:0]       wdata_o;
    logic [BE_WIDTH-1:0]         be_o;
    logic                        gnt_i;
    logic                        r_valid_i;
    logic [DATA_WIDTH-1:0]       r_rdata_i;
    logic                        r_opc_i;

    // Sticky protocol error flag
    logic                        resp_err_o;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i,
        output gnt_o, r_valid_o, r_rdata_o, r_opc_o,
        output req_o, add_o, wen_o, wdata_o, be_o,
        input  gnt_i, r_valid_i, r_rdata_i, r_opc_i,
        output resp_err_o
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_opc_o,
        input  req_o, add_o, wen_o, wdata_o, be_o,
        output gnt_i, r_valid_i, r_rdata_i, r_opc_i,
        input  resp_err_o
    );
endinterface

// File: rtl/fc_l2_port_arbiter.sv
// fc_l2_port_arbiter: shares one TCDM-style L2 port between N_REQ requesters.
// It uses round-robin arbitration. The chosen request is locked until it is
// granted, so the address and data seen by L2 stay stable. An in-order tag
// FIFO routes each response back to the requester that issued the request.
// Optional macro FC_L2_ARB_CORE_PRIO_EN gives requester 0 fixed priority.
// The remaining requesters then share a rotating pointer among themselves.
//
// Handshake semantics: a request transfers at a rising edge where
// req_o & gnt_i. Until that edge the winner is locked. The requester must
// hold its request stable. A response (r_valid_i) pops the oldest tag. The
// response is valid for exactly one cycle and has no back-pressure.
module fc_l2_port_arbiter #(
    parameter int N_REQ           = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fc_l2_port_arbiter_if.slave  bus,
    output logic                 dbg_locked_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W    = PTR_W + 1;

    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

    lock_state_e      lock_q, lock_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] locked_idx_q, locked_idx_d;
    logic [IDX_W-1:0] tag_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] tag_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             resp_err_q, resp_err_d;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] scan_idx;
    int               scan_sum;
    logic             found;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    assign fifo_full    = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty   = (count_q == '0);
    assign dbg_locked_o = (lock_q == LK_HELD);

    // Pick the winner: the locked requester, else the first request found in priority order.
    always_comb begin
        winner   = rr_ptr_q;
        scan_idx = '0;
        scan_sum = 0;
        found    = 1'b0;
        if (lock_q == LK_HELD) begin
            winner = locked_idx_q;
        end else begin
`ifdef FC_L2_ARB_CORE_PRIO_EN
            if (bus.req_i[0]) begin
                winner = '0;
            end else begin
                // Rotate among 1..N_REQ-1. A pointer of 0 means "start at 1".
                for (int k = 0; k < N_REQ - 1; k++) begin
                    scan_sum = ((rr_ptr_q == '0) ? 1 : int'(rr_ptr_q)) + k;
                    if (scan_sum >= N_REQ) scan_sum = scan_sum - (N_REQ - 1);
                    scan_idx = IDX_W'(scan_sum);
                    if (!found && bus.req_i[scan_idx]) begin
                        winner = scan_idx;
                        found  = 1'b1;
                    end
                end
            end
`else
            for (int k = 0; k < N_REQ; k++) begin
                scan_sum = int'(rr_ptr_q) + k;
                if (scan_sum >= N_REQ) scan_sum = scan_sum - N_REQ;
                scan_idx = IDX_W'(scan_sum);
                if (!found && bus.req_i[scan_idx]) begin
                    winner = scan_idx;
                    found  = 1'b1;
                end
            end
`endif
        end
    end

    // Drive the L2 request and the per-requester grant/response strobes.
    // A full FIFO blocks the request even if a pop happens in the same cycle.
    // This keeps r_valid_i out of the combinational path to req_o and gnt_o.
    always_comb begin
        bus.req_o     = rst_ni & bus.req_i[winner] & ~fifo_full;
        bus.add_o     = '0;
        bus.wen_o     = 1'b1;
        bus.wdata_o   = '0;
        bus.be_o      = '0;
        bus.gnt_o     = '0;
        bus.r_valid_o = '0;
        push          = bus.req_o & bus.gnt_i;
        pop           = bus.r_valid_i & ~fifo_empty;
        if (bus.req_o) begin
            bus.add_o   = bus.add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.wen_o   = bus.wen_i[winner];
            bus.wdata_o = bus.wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            bus.be_o    = bus.be_i[int'(winner)*BE_WIDTH +: BE_WIDTH];
        end
        if (push) bus.gnt_o[winner] = 1'b1;
        if (pop) bus.r_valid_o[tag_q[rd_ptr_q]] = 1'b1;
    end

    assign bus.r_rdata_o  = bus.r_rdata_i;
    assign bus.r_opc_o    = bus.r_opc_i;
    assign bus.resp_err_o = resp_err_q;

    // Next state for lock, round-robin pointer, tag FIFO and error flag.
    always_comb begin
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        rr_ptr_d     = rr_ptr_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        resp_err_d   = resp_err_q | (bus.r_valid_i & fifo_empty);

        if (push) begin
            lock_d          = LK_OPEN;
            tag_d[wr_ptr_q] = winner;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
`ifdef FC_L2_ARB_CORE_PRIO_EN
            if (winner != '0) begin
                rr_ptr_d = (winner == IDX_W'(N_REQ - 1)) ? IDX_W'(1) : winner + IDX_W'(1);
            end
`else
            rr_ptr_d = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
`endif
        end else if (bus.req_o) begin
            lock_d       = LK_HELD;
            locked_idx_d = winner;
        end else if (lock_q == LK_HELD && !bus.req_i[locked_idx_q]) begin
            // The locked requester withdrew its request: release the port.
            lock_d = LK_OPEN;
        end

        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers; reset flushes the tag FIFO and clears the error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q       <= LK_OPEN;
            locked_idx_q <= '0;
            rr_ptr_q     <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            resp_err_q   <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Testbench for fc_l2_port_arbiter.
// A reference model of the arbitration rules and the in-order tag queue
// predicts every output. Directed scenarios run first, then a randomized
// phase.
module tb_fc_l2_port_arbiter;
  localparam int N_REQ           = 3;
  localparam int ADDR_WIDTH      = 32;
  localparam int DATA_WIDTH      = 32;
  localparam int BE_WIDTH        = DATA_WIDTH / 8;
  localparam int MAX_OUTSTANDING = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_locked;
  always #5 clk = ~clk;

  fc_l2_port_arbiter_if #(.N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fc_l2_port_arbiter #(
    .N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .dbg_locked_o(dbg_locked)
  );

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];     // requester index of each granted, unanswered request
  int  m_rr   = 0;
  bit  m_lock = 0;
  int  m_lidx = 0;
  bit  m_err  = 0;
  logic [N_REQ-1:0] last_gnt;
  logic obs_req, obs_err;
  logic [N_REQ-1:0] obs_rv;
  logic [ADDR_WIDTH-1:0] obs_add;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_rr = 0; m_lock = 0; m_lidx = 0; m_err = 0;
  endfunction

  // The requester that should own the port this cycle, or -1 when there is none.
  function automatic int model_winner();
    int i, start;
    if (m_lock) return m_lidx;
`ifdef FC_L2_ARB_CORE_PRIO_EN
    if (bus.req_i[0]) return 0;
    start = (m_rr == 0) ? 1 : m_rr;
    for (int k = 0; k < N_REQ - 1; k++) begin
      i = 1 + ((start - 1 + k) % (N_REQ - 1));
      if (bus.req_i[i]) return i;
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      i = (m_rr + k) % N_REQ;
      if (bus.req_i[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic int next_rr(input int w);
`ifdef FC_L2_ARB_CORE_PRIO_EN
    if (w == 0) return m_rr;
    return 1 + (w % (N_REQ - 1));
`else
    return (w + 1) % N_REQ;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic new_payload(input int i);
    bus.add_i[i*ADDR_WIDTH +: ADDR_WIDTH] = $urandom;
    bus.wdata_i[i*DATA_WIDTH +: DATA_WIDTH] = $urandom;
    bus.be_i[i*BE_WIDTH +: BE_WIDTH] = BE_WIDTH'($urandom_range(0, (1 << BE_WIDTH) - 1));
    bus.wen_i[i] = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge with inputs already applied. Checks outputs,
  // advances the model across the next rising edge, returns at the following negedge.
  task automatic cycle(input string ph);
    int w;
    logic ereq;
    logic [N_REQ-1:0] egnt, erv;
    logic [ADDR_WIDTH-1:0] eadd;
    logic [DATA_WIDTH-1:0] ewd;
    logic [BE_WIDTH-1:0] ebe;
    logic ewen;
    if (!rst_n) model_reset();
    #2;
    w = model_winner();
    ereq = 1'b0;
    if (rst_n && w >= 0) ereq = bus.req_i[w] && (exp_q.size() < MAX_OUTSTANDING);
    eadd = '0; ewd = '0; ebe = '0; ewen = 1'b1; egnt = '0; erv = '0;
    if (ereq) begin
      eadd = bus.add_i[w*ADDR_WIDTH +: ADDR_WIDTH];
      ewd  = bus.wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
      ebe  = bus.be_i[w*BE_WIDTH +: BE_WIDTH];
      ewen = bus.wen_i[w];
      if (bus.gnt_i) egnt[w] = 1'b1;
    end
    if (bus.r_valid_i && exp_q.size() > 0) erv[exp_q[0]] = 1'b1;
    check({ph, "_req_o"}, bus.req_o, ereq);
    check({ph, "_gnt_o"}, bus.gnt_o, egnt);
    check({ph, "_add_o"}, bus.add_o, eadd);
    check({ph, "_wdata_o"}, bus.wdata_o, ewd);
    check({ph, "_be_o"}, bus.be_o, ebe);
    check({ph, "_wen_o"}, bus.wen_o, ewen);
    check({ph, "_r_valid_o"}, bus.r_valid_o, erv);
    check({ph, "_r_rdata_o"}, bus.r_rdata_o, bus.r_rdata_i);
    check({ph, "_r_opc_o"}, bus.r_opc_o, bus.r_opc_i);
    check({ph, "_resp_err_o"}, bus.resp_err_o, m_err);
    check({ph, "_locked"}, dbg_locked, m_lock);
    obs_req = bus.req_o; obs_rv = bus.r_valid_o; obs_add = bus.add_o; obs_err = bus.resp_err_o;
    if (rst_n) begin
      if (bus.r_valid_i) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else m_err = 1;
      end
      if (ereq && bus.gnt_i) begin
        exp_q.push_back(8'(w));
        m_rr = next_rr(w);
        m_lock = 0;
      end else if (ereq) begin
        m_lock = 1;
        m_lidx = w;
      end else if (m_lock && !bus.req_i[m_lidx]) begin
        m_lock = 0;
      end
    end
    last_gnt = egnt;
    @(negedge clk);
  endtask

  // Withdraw all requests and answer everything outstanding.
  task automatic drain();
    bus.req_i = '0;
    bus.gnt_i = 1'b0;
    for (int c = 0; c < MAX_OUTSTANDING + 2; c++) begin
      bus.r_valid_i = (exp_q.size() > 0);
      bus.r_rdata_i = $urandom;
      cycle("drain");
    end
    bus.r_valid_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_gr;
    logic [N_REQ-1:0] exp_alt;
    bus.req_i = '0; bus.add_i = '0; bus.wen_i = '1; bus.wdata_i = '0; bus.be_i = '0;
    bus.gnt_i = 1'b0; bus.r_valid_i = 1'b0; bus.r_rdata_i = '0; bus.r_opc_i = 1'b0;
    last_gnt = '0;
    @(negedge clk);
    cycle("rst");
    cycle("rst");
    rst_n = 1'b1;

    // Two requesters always pending, L2 always grants and answers one cycle later.
    for (int i = 0; i < N_REQ; i++) new_payload(i);
    bus.req_i = 3'b011;
    bus.gnt_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.r_valid_i = (exp_q.size() > 0);
      bus.r_rdata_i = $urandom;
      bus.r_opc_i = 1'($urandom_range(0, 1));
      cycle("t1");
`ifdef FC_L2_ARB_CORE_PRIO_EN
      exp_alt = 3'b001;
`else
      exp_alt = (c % 2 == 0) ? 3'b001 : 3'b010;
`endif
      check("t1_alternate", last_gnt, exp_alt);
    end
    drain();

    // A stalled request stays locked even after a competing request appears.
    bus.add_i[1*ADDR_WIDTH +: ADDR_WIDTH] = 32'h1111_0000;
    bus.add_i[0*ADDR_WIDTH +: ADDR_WIDTH] = 32'h2222_0000;
    bus.req_i = 3'b010;
    bus.gnt_i = 1'b0;
    cycle("t2");
    check("t2_hold_c1", obs_add, 32'h1111_0000);
    bus.req_i = 3'b011;
    cycle("t2");
    check("t2_hold_c2", obs_add, 32'h1111_0000);
    cycle("t2");
    check("t2_hold_c3", obs_add, 32'h1111_0000);
    bus.gnt_i = 1'b1;
    cycle("t2");
    check("t2_gnt1", last_gnt, 3'b010);
    bus.req_i = 3'b001;
    cycle("t2");
    check("t2_gnt0_next", last_gnt, 3'b001);
    drain();

    // A single requester fills the tag FIFO and then stalls until a response frees a slot.
    bus.req_i = 3'b001;
    bus.gnt_i = 1'b1;
    n_gr = 0;
    for (int c = 0; c < MAX_OUTSTANDING + 2; c++) begin
      cycle("t3");
      n_gr += int'(last_gnt[0]);
    end
    check("t3_grants", n_gr, MAX_OUTSTANDING);
    check("t3_full_stall", obs_req, 1'b0);
    bus.r_valid_i = 1'b1;
    cycle("t3");
    check("t3_rvalid0", obs_rv, 3'b001);
    bus.r_valid_i = 1'b0;
    cycle("t3");
    check("t3_resume", obs_req, 1'b1);
    drain();

    // A response with nothing outstanding sets a sticky error. Asynchronous reset clears it.
    bus.r_valid_i = 1'b1;
    cycle("t4");
    check("t4_no_rvalid", obs_rv, 3'b000);
    bus.r_valid_i = 1'b0;
    cycle("t4");
    check("t4_err_set", obs_err, 1'b1);
    cycle("t4");
    check("t4_err_sticky", obs_err, 1'b1);
    bus.req_i = 3'b001;
    bus.gnt_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async_err", bus.resp_err_o, 1'b0);
    check("t4_async_req", bus.req_o, 1'b0);
    @(negedge clk);
    cycle("t4rst");
    bus.req_i = '0;
    cycle("t4rst");
    rst_n = 1'b1;

    // Reset while two requests are outstanding flushes the tags and the pointer.
    bus.gnt_i = 1'b1;
    bus.req_i = 3'b010;
    cycle("t5");
    bus.req_i = 3'b001;
    cycle("t5");
    bus.req_i = 3'b000;
    bus.gnt_i = 1'b0;
    rst_n = 1'b0;
    cycle("t5rst");
    cycle("t5rst");
    rst_n = 1'b1;
    bus.r_valid_i = 1'b1;
    cycle("t5");
    check("t5_stale_rvalid", obs_rv, 3'b000);
    bus.r_valid_i = 1'b0;
    cycle("t5");
    check("t5_err", obs_err, 1'b1);
    bus.req_i = 3'b011;
    bus.gnt_i = 1'b1;
    cycle("t5");
    check("t5_rr_reset", last_gnt, 3'b001);
    drain();

    // Randomized traffic, including occasional withdrawn (unlocked) requests.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_i[i]) begin
          if (last_gnt[i]) begin
            bus.req_i[i] = 1'($urandom_range(0, 1));
            if (bus.req_i[i]) new_payload(i);
          end else if ($urandom_range(0, 31) == 0) begin
            bus.req_i[i] = 1'b0;
          end
        end else if ($urandom_range(0, 1) == 1) begin
          bus.req_i[i] = 1'b1;
          new_payload(i);
        end
      end
      bus.gnt_i = ($urandom_range(0, 9) < 7);
      bus.r_valid_i = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.r_rdata_i = $urandom;
      bus.r_opc_i = 1'($urandom_range(0, 1));
      cycle("rnd");
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
